// File: rtl/fifo1_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo1_pkg
//  Brief    : Shared defaults and pointer-width helper for the fifo1 FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package fifo1_pkg;

    localparam int FIFO1_DEPTH_DEFAULT = 16;
    localparam int FIFO1_WIDTH_DEFAULT = 8;

    // One extra MSB on each pointer separates the full case from the empty case.
    function automatic int fifo1_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo1_pkg
`default_nettype wire

// File: rtl/fifo1_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo1_mem
//  Brief    : DEPTH x WIDTH storage, one synchronous write port and one
//             synchronous read port with a resettable registered output.
//  Revision : 1.0  initial release
// ============================================================================
module fifo1_mem
    import fifo1_pkg::*;
#(
    parameter int DEPTH = FIFO1_DEPTH_DEFAULT,
    parameter int WIDTH = FIFO1_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Array has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo1_mem
`default_nettype wire

// File: rtl/fifo1.sv
`default_nettype none
// ============================================================================
//  Module   : fifo1
//  Brief    : Single-clock FIFO with registered read data and not-empty /
//             not-full status. Define FIFO1_COUNT_EN to add an occupancy port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo1
    import fifo1_pkg::*;
#(
    parameter int DEPTH = FIFO1_DEPTH_DEFAULT,
    parameter int WIDTH = FIFO1_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   put,
    input  logic                   get,
    input  logic [WIDTH-1:0]       data_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   empty_bar,
    output logic                   full_bar
`ifdef FIFO1_COUNT_EN
    ,
    output logic [$clog2(DEPTH):0] count
`endif
);

    localparam int PW = fifo1_ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_rd_en;

    // Full: same slot index but one pointer has lapped the other.
    always_comb begin
        w_empty = (wptr_q == rptr_q);
        w_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        w_wr_en = put & ~w_full;
        w_rd_en = get & ~w_empty;
        wptr_d  = wptr_q + {{(PW-1){1'b0}}, w_wr_en};
        rptr_d  = rptr_q + {{(PW-1){1'b0}}, w_rd_en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo1_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_wr_en),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (w_rd_en),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (data_out)
    );

    assign empty_bar = ~w_empty;
    assign full_bar  = ~w_full;

`ifdef FIFO1_COUNT_EN
    // Modulo-2*DEPTH difference yields 0..DEPTH without extra state.
    assign count = wptr_q - rptr_q;
`endif

endmodule : fifo1
`default_nettype wire

// File: tb/tb_fifo1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo1
//  Brief    : Self-checking bench for fifo1 using a queue-based reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo1;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             put;
    logic             get;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             empty_bar;
    logic             full_bar;
`ifdef FIFO1_COUNT_EN
    logic [4:0]       count;
`endif

    int               checks;
    int               errors;
    logic [WIDTH-1:0] model [$];
    logic [WIDTH-1:0] exp_dout;

    fifo1 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .put       (put),
        .get       (get),
        .data_in   (data_in),
        .data_out  (data_out),
        .empty_bar (empty_bar),
        .full_bar  (full_bar)
`ifdef FIFO1_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle and updates the reference on pre-edge occupancy.
    task automatic do_cycle(input logic p, input logic g, input logic [WIDTH-1:0] d);
        bit wr;
        bit rd;
        put     = p;
        get     = g;
        data_in = d;
        wr = p && (model.size() < DEPTH);
        rd = g && (model.size() > 0);
        if (rd) exp_dout = model.pop_front();
        if (wr) model.push_back(d);
        @(posedge clk);
        #1;
        put = 1'b0;
        get = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        put     = 1'b1;
        get     = 1'b1;
        data_in = 8'h77;
        #80;
        put   = 1'b0;
        get   = 1'b0;
        reset = 1'b1;
        model.delete();
        exp_dout = '0;
        @(posedge clk);
        #1;
        checks++;
        if (empty_bar !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty_bar got %b exp 0", empty_bar);
        end
        checks++;
        if (full_bar !== 1'b1) begin
            errors++;
            $display("FAIL reset_full_bar got %b exp 1", full_bar);
        end
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data_out got %h exp 00", data_out);
        end
`ifdef FIFO1_COUNT_EN
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", count);
        end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1'b1, 1'b0, 8'(i));
            checks++;
            if (empty_bar !== 1'b1) begin
                errors++;
                $display("FAIL fill_empty_bar i=%0d got %b exp 1", i, empty_bar);
            end
            checks++;
            if (full_bar !== (i < DEPTH)) begin
                errors++;
                $display("FAIL fill_full_bar i=%0d got %b exp %b", i, full_bar, (i < DEPTH));
            end
        end
        do_cycle(1'b1, 1'b0, 8'hFF);
        checks++;
        if (full_bar !== 1'b0 || model.size() != DEPTH) begin
            errors++;
            $display("FAIL fill_overflow full_bar got %b exp 0", full_bar);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== exp_dout || data_out !== 8'(i)) begin
                errors++;
                $display("FAIL drain_data i=%0d got %h exp %h", i, data_out, 8'(i));
            end
            checks++;
            if (empty_bar !== (i < DEPTH) || full_bar !== 1'b1) begin
                errors++;
                $display("FAIL drain_flags i=%0d got ne=%b nf=%b exp ne=%b nf=1",
                         i, empty_bar, full_bar, (i < DEPTH));
            end
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h10 || empty_bar !== 1'b0) begin
            errors++;
            $display("FAIL drain_underflow got data=%h ne=%b exp data=10 ne=0", data_out, empty_bar);
        end
    endtask

    task automatic test_simul_empty();
        do_cycle(1'b1, 1'b1, 8'hA0);
        checks++;
        if (empty_bar !== 1'b1 || data_out !== exp_dout) begin
            errors++;
            $display("FAIL simul_empty_first got ne=%b data=%h exp ne=1 data=%h",
                     empty_bar, data_out, exp_dout);
        end
        for (int i = 1; i < 16; i++) begin
            do_cycle(1'b1, 1'b1, 8'hA0 + 8'(i));
            checks++;
            if (data_out !== exp_dout || data_out !== 8'hA0 + 8'(i - 1)) begin
                errors++;
                $display("FAIL simul_stream_data i=%0d got %h exp %h", i, data_out, 8'hA0 + 8'(i - 1));
            end
            checks++;
            if (empty_bar !== 1'b1 || full_bar !== 1'b1) begin
                errors++;
                $display("FAIL simul_stream_flags i=%0d got ne=%b nf=%b exp 1 1", i, empty_bar, full_bar);
            end
`ifdef FIFO1_COUNT_EN
            checks++;
            if (count !== 5'd1) begin
                errors++;
                $display("FAIL simul_stream_count i=%0d got %0d exp 1", i, count);
            end
`endif
        end
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'hAF || empty_bar !== 1'b0) begin
            errors++;
            $display("FAIL simul_stream_tail got data=%h ne=%b exp data=AF ne=0", data_out, empty_bar);
        end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'h30 + 8'(i));
        checks++;
        if (full_bar !== 1'b0) begin
            errors++;
            $display("FAIL simul_full_pre got nf=%b exp 0", full_bar);
        end
        do_cycle(1'b1, 1'b1, 8'h55);
        checks++;
        if (data_out !== 8'h30 || full_bar !== 1'b1) begin
            errors++;
            $display("FAIL simul_full_pop got data=%h nf=%b exp data=30 nf=1", data_out, full_bar);
        end
        for (int i = 1; i < DEPTH; i++) begin
            do_cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== exp_dout || data_out !== 8'h30 + 8'(i)) begin
                errors++;
                $display("FAIL simul_full_drain i=%0d got %h exp %h", i, data_out, 8'h30 + 8'(i));
            end
        end
        checks++;
        if (empty_bar !== 1'b0) begin
            errors++;
            $display("FAIL simul_full_dropped got ne=%b exp 0", empty_bar);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] pat [3];
        pat[0] = 8'h11;
        pat[1] = 8'h22;
        pat[2] = 8'h33;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 3; k++) do_cycle(1'b1, 1'b0, pat[k]);
`ifdef FIFO1_COUNT_EN
            checks++;
            if (count !== 5'd3) begin
                errors++;
                $display("FAIL wrap_count_full r=%0d got %0d exp 3", r, count);
            end
`endif
            checks++;
            if (empty_bar !== 1'b1 || full_bar !== 1'b1) begin
                errors++;
                $display("FAIL wrap_flags_mid r=%0d got ne=%b nf=%b exp 1 1", r, empty_bar, full_bar);
            end
            for (int k = 0; k < 3; k++) begin
                do_cycle(1'b0, 1'b1, 8'h00);
                checks++;
                if (data_out !== exp_dout || data_out !== pat[k]) begin
                    errors++;
                    $display("FAIL wrap_data r=%0d k=%0d got %h exp %h", r, k, data_out, pat[k]);
                end
            end
            checks++;
            if (empty_bar !== 1'b0 || full_bar !== 1'b1) begin
                errors++;
                $display("FAIL wrap_flags_end r=%0d got ne=%b nf=%b exp 0 1", r, empty_bar, full_bar);
            end
`ifdef FIFO1_COUNT_EN
            checks++;
            if (count !== 5'd0) begin
                errors++;
                $display("FAIL wrap_count_empty r=%0d got %0d exp 0", r, count);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
        do_cycle(1'b0, 1'b1, 8'h00);
        #2;
        reset = 1'b0;
        model.delete();
        exp_dout = '0;
        #1;
        checks++;
        if (empty_bar !== 1'b0 || full_bar !== 1'b1 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async got ne=%b nf=%b data=%h exp 0 1 00",
                     empty_bar, full_bar, data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        do_cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== 8'h00 || empty_bar !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_discard got data=%h ne=%b exp 00 0", data_out, empty_bar);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_dout = '0;
        put      = 1'b0;
        get      = 1'b0;
        data_in  = '0;
        test_reset();
        test_fill();
        test_drain();
        test_simul_empty();
        test_simul_full();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo1
`default_nettype wire
